// File: rtl/wb_burst_ram.sv
// Wishbone B3 byte-addressed RAM with classic and incrementing/wrapping bursts.
// A request is answered one clock later; bursts then run at one beat per clock, and stb low holds the pending beat.
module wb_burst_ram #(
    parameter int dw    = 32,
    parameter int aw    = 32,
    parameter int depth = 1024
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic [aw-1:0] wb_adr_i,
    input  logic [dw-1:0] wb_dat_i,
    input  logic [3:0]    wb_sel_i,
    input  logic          wb_we_i,
    input  logic          wb_cyc_i,
    input  logic          wb_stb_i,
    input  logic [2:0]    wb_cti_i,
    input  logic [1:0]    wb_bte_i,
    output logic [dw-1:0] wb_dat_o,
    output logic          wb_ack_o,
    output logic          wb_err_o,
    output logic          wb_rty_o
);
    localparam int words = depth / 4;
    localparam int iw    = $clog2(words);
    localparam int cw    = aw - 2;

    typedef enum logic {IDLE, BURST} state_t;

    state_t        state, state_nxt;
    logic          ack_pend, ack_pend_nxt;
    logic          err_pend, err_pend_nxt;
    logic [cw-1:0] cnt, cnt_nxt, cnt_inc, adr_word;
    logic [dw-1:0] dat_q, dat_nxt;
    logic [dw-1:0] mem [words];
    logic          req, mem_we;
    logic          unused_adr;

    function automatic logic in_range(input logic [cw-1:0] w);
        return (w >> iw) == '0;
    endfunction

    assign adr_word   = wb_adr_i[aw-1:2];
    assign unused_adr = ^wb_adr_i[1:0];
    assign req        = wb_cyc_i & wb_stb_i;

    // The registered termination only reaches the bus while the master is strobing,
    // so a dropped cyc or a stb gap never sees a stray ack.
    assign wb_ack_o = ack_pend & req;
    assign wb_err_o = err_pend & req;
    assign wb_rty_o = 1'b0;
    assign wb_dat_o = dat_q;
    assign mem_we   = wb_ack_o & wb_we_i;

    always_comb begin
        cnt_inc = cnt + cw'(1);
        case (wb_bte_i)
            2'b01:   cnt_inc = {cnt[cw-1:2], cnt[1:0] + 2'd1};
            2'b10:   cnt_inc = {cnt[cw-1:3], cnt[2:0] + 3'd1};
            2'b11:   cnt_inc = {cnt[cw-1:4], cnt[3:0] + 4'd1};
            default: ;
        endcase
    end

    always_comb begin
        state_nxt    = state;
        ack_pend_nxt = ack_pend;
        err_pend_nxt = err_pend;
        cnt_nxt      = cnt;
        dat_nxt      = dat_q;
        case (state)
            IDLE: begin
                ack_pend_nxt = 1'b0;
                err_pend_nxt = 1'b0;
                if (req && !wb_ack_o && !wb_err_o) begin
                    cnt_nxt = adr_word;
                    if (in_range(adr_word)) begin
                        ack_pend_nxt = 1'b1;
                        dat_nxt      = mem[adr_word[iw-1:0]];
                        if (wb_cti_i == 3'b010)
                            state_nxt = BURST;
                    end else begin
                        err_pend_nxt = 1'b1;
                        dat_nxt      = '0;
                    end
                end
            end
            BURST: begin
                if (!wb_cyc_i) begin
                    state_nxt    = IDLE;
                    ack_pend_nxt = 1'b0;
                    err_pend_nxt = 1'b0;
                end else if (wb_stb_i) begin
                    // A termination is always pending here, so stb high completes a beat.
                    if (err_pend || wb_cti_i != 3'b010) begin
                        state_nxt    = IDLE;
                        ack_pend_nxt = 1'b0;
                        err_pend_nxt = 1'b0;
                    end else begin
                        cnt_nxt = cnt_inc;
                        if (in_range(cnt_inc)) begin
                            ack_pend_nxt = 1'b1;
                            dat_nxt      = mem[cnt_inc[iw-1:0]];
                        end else begin
                            ack_pend_nxt = 1'b0;
                            err_pend_nxt = 1'b1;
                            dat_nxt      = '0;
                        end
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state    <= IDLE;
            ack_pend <= 1'b0;
            err_pend <= 1'b0;
            cnt      <= '0;
            dat_q    <= '0;
        end else begin
            state    <= state_nxt;
            ack_pend <= ack_pend_nxt;
            err_pend <= err_pend_nxt;
            cnt      <= cnt_nxt;
            dat_q    <= dat_nxt;
        end
    end

    // The counter always holds the address of the beat currently being terminated.
    always_ff @(posedge wb_clk_i) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (wb_sel_i[i])
                    mem[cnt[iw-1:0]][8*i +: 8] <= wb_dat_i[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_wb_burst_ram.sv
module tb_wb_burst_ram;
    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic [31:0] wb_adr_i = '0;
    logic [31:0] wb_dat_i = '0;
    logic [3:0]  wb_sel_i = '0;
    logic        wb_we_i  = 1'b0;
    logic        wb_cyc_i = 1'b0;
    logic        wb_stb_i = 1'b0;
    logic [2:0]  wb_cti_i = '0;
    logic [1:0]  wb_bte_i = '0;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o, wb_err_o, wb_rty_o;

    int checks   = 0;
    int failures = 0;

    wb_burst_ram #(.dw(32), .aw(32), .depth(1024)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .wb_adr_i(wb_adr_i),
        .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_cti_i(wb_cti_i),
        .wb_bte_i(wb_bte_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
        .wb_err_o(wb_err_o), .wb_rty_o(wb_rty_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic idle_bus();
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; wb_adr_i = '0;
        wb_dat_i = '0;   wb_sel_i = '0;   wb_cti_i = '0;  wb_bte_i = '0;
    endtask

    // Classic cycle; stb is held one cycle past the termination to observe the low gap.
    task automatic classic(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, output logic early, output logic ack,
                           output logic err, output logic [31:0] rdat, output logic late);
        @(posedge wb_clk_i); #1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we; wb_adr_i = adr;
        wb_dat_i = dat;  wb_sel_i = sel;  wb_cti_i = 3'b000; wb_bte_i = 2'b00;
        @(negedge wb_clk_i); early = wb_ack_o | wb_err_o;
        @(negedge wb_clk_i); ack = wb_ack_o; err = wb_err_o; rdat = wb_dat_o;
        @(negedge wb_clk_i); late = wb_ack_o | wb_err_o;
        @(posedge wb_clk_i); #1; idle_bus();
    endtask

    // Read burst; wb_adr_i stays at the start address so only the internal counter can step.
    task automatic read_burst(input logic [31:0] start, input logic [1:0] bte, input int n,
                              output logic early, output logic [7:0] acks,
                              output logic [7:0] errs, output logic [255:0] dats);
        acks = '0; errs = '0; dats = '0;
        @(posedge wb_clk_i); #1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = start;
        wb_sel_i = 4'hF; wb_cti_i = 3'b010; wb_bte_i = bte;
        @(negedge wb_clk_i); early = wb_ack_o | wb_err_o;
        for (int b = 0; b < n; b++) begin
            @(posedge wb_clk_i); #1;
            wb_cti_i = (b == n - 1) ? 3'b111 : 3'b010;
            @(negedge wb_clk_i);
            acks[b] = wb_ack_o; errs[b] = wb_err_o; dats[32*b +: 32] = wb_dat_o;
        end
        @(posedge wb_clk_i); #1; idle_bus();
    endtask

    task automatic test_reset();
        @(posedge wb_clk_i); #1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_adr_i = 32'h10;
        for (int c = 0; c < 3; c++) begin
            @(negedge wb_clk_i);
            checks++;
            if ({wb_ack_o, wb_err_o, wb_rty_o} !== 3'b000 || wb_dat_o !== 32'h0) begin
                failures++;
                $display("FAIL reset_outputs: ack/err/rty=%b%b%b dat=%h, expected 000 and 0",
                         wb_ack_o, wb_err_o, wb_rty_o, wb_dat_o);
            end
        end
        @(posedge wb_clk_i); #1; idle_bus(); wb_rst_i = 1'b0;
    endtask

    task automatic test_classic();
        logic e, a, r, l; logic [31:0] d;
        classic(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, e, a, r, d, l);
        checks++;
        if ({e, a, r, l} !== 4'b0100) begin
            failures++; $display("FAIL classic_wr_timing: early/ack/err/late=%b%b%b%b expected 0100", e, a, r, l);
        end
        classic(1'b0, 32'h10, 32'h0, 4'hF, e, a, r, d, l);
        checks++;
        if ({e, a, r, l} !== 4'b0100) begin
            failures++; $display("FAIL classic_rd_timing: early/ack/err/late=%b%b%b%b expected 0100", e, a, r, l);
        end
        checks++;
        if (d !== 32'hDEADBEEF) begin
            failures++; $display("FAIL classic_rd_data: got %h expected deadbeef", d);
        end
    endtask

    task automatic test_byte_lanes();
        logic e, a, r, l; logic [31:0] d;
        classic(1'b1, 32'h10, 32'h000000AA, 4'b0001, e, a, r, d, l);
        classic(1'b0, 32'h10, 32'h0, 4'b0000, e, a, r, d, l);
        checks++;
        if (d !== 32'hDEADBEAA) begin
            failures++; $display("FAIL lane0_write: got %h expected deadbeaa", d);
        end
        classic(1'b1, 32'h10, 32'h11775533, 4'b0100, e, a, r, d, l);
        classic(1'b0, 32'h10, 32'h0, 4'b0010, e, a, r, d, l);
        checks++;
        if (d !== 32'hDE77BEAA) begin
            failures++; $display("FAIL lane2_write: got %h expected de77beaa", d);
        end
    endtask

    task automatic test_cyc_drop();
        logic e, a, r, l; logic [31:0] d;
        @(posedge wb_clk_i); #1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = 32'h10;
        wb_dat_i = 32'h12345678; wb_sel_i = 4'hF; wb_cti_i = 3'b000;
        @(posedge wb_clk_i); #1; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        @(negedge wb_clk_i);
        checks++;
        if (wb_ack_o !== 1'b0) begin
            failures++; $display("FAIL cyc_drop_ack: got %b expected 0", wb_ack_o);
        end
        @(posedge wb_clk_i); #1; idle_bus();
        classic(1'b0, 32'h10, 32'h0, 4'hF, e, a, r, d, l);
        checks++;
        if (d !== 32'hDE77BEAA) begin
            failures++; $display("FAIL cyc_drop_nowrite: got %h expected de77beaa", d);
        end
    endtask

    task automatic preload();
        logic e, a, r, l; logic [31:0] d;
        for (int w = 12; w < 32; w++)
            classic(1'b1, 32'(w * 4), 32'hA5000000 | 32'(w * 4), 4'hF, e, a, r, d, l);
        classic(1'b1, 32'h3F8, 32'h5A0003F8, 4'hF, e, a, r, d, l);
        classic(1'b1, 32'h3FC, 32'h5A0003FC, 4'hF, e, a, r, d, l);
    endtask

    task automatic test_wrap();
        logic e; logic [7:0] acks, errs; logic [255:0] dats;
        logic [31:0] w4 [4];
        logic [31:0] w8 [3];
        w4 = '{32'h38, 32'h3C, 32'h30, 32'h34};
        read_burst(32'h38, 2'b01, 4, e, acks, errs, dats);
        checks++;
        if (e !== 1'b0 || acks[3:0] !== 4'hF || errs[3:0] !== 4'h0) begin
            failures++; $display("FAIL wrap4_acks: early=%b acks=%b errs=%b expected 0 1111 0000", e, acks[3:0], errs[3:0]);
        end
        for (int b = 0; b < 4; b++) begin
            checks++;
            if (dats[32*b +: 32] !== (32'hA5000000 | w4[b])) begin
                failures++; $display("FAIL wrap4_data beat %0d: got %h expected %h", b, dats[32*b +: 32], 32'hA5000000 | w4[b]);
            end
        end
        w8 = '{32'h58, 32'h5C, 32'h40};
        read_burst(32'h58, 2'b10, 3, e, acks, errs, dats);
        for (int b = 0; b < 3; b++) begin
            checks++;
            if (acks[b] !== 1'b1 || dats[32*b +: 32] !== (32'hA5000000 | w8[b])) begin
                failures++; $display("FAIL wrap8 beat %0d: ack=%b got %h expected ack 1 data %h", b, acks[b], dats[32*b +: 32], 32'hA5000000 | w8[b]);
            end
        end
        w8 = '{32'h78, 32'h7C, 32'h40};
        read_burst(32'h78, 2'b11, 3, e, acks, errs, dats);
        for (int b = 0; b < 3; b++) begin
            checks++;
            if (acks[b] !== 1'b1 || dats[32*b +: 32] !== (32'hA5000000 | w8[b])) begin
                failures++; $display("FAIL wrap16 beat %0d: ack=%b got %h expected ack 1 data %h", b, acks[b], dats[32*b +: 32], 32'hA5000000 | w8[b]);
            end
        end
    endtask

    task automatic test_linear_write_gap();
        logic e, a, r, l; logic [31:0] d;
        @(posedge wb_clk_i); #1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = 32'h0;
        wb_dat_i = 32'hC0DE0000; wb_sel_i = 4'hF; wb_cti_i = 3'b010; wb_bte_i = 2'b00;
        @(negedge wb_clk_i);
        checks++;
        if (wb_ack_o !== 1'b0) begin
            failures++; $display("FAIL lin_first_latency: ack=%b expected 0", wb_ack_o);
        end
        for (int b = 0; b < 8; b++) begin
            if (b == 3) begin
                for (int g = 0; g < 2; g++) begin
                    @(posedge wb_clk_i); #1; wb_stb_i = 1'b0; wb_dat_i = 32'hFFFFFFFF;
                    @(negedge wb_clk_i);
                    checks++;
                    if (wb_ack_o !== 1'b0) begin
                        failures++; $display("FAIL lin_gap_ack cycle %0d: ack=%b expected 0", g, wb_ack_o);
                    end
                end
            end
            @(posedge wb_clk_i); #1;
            wb_stb_i = 1'b1; wb_adr_i = 32'(b * 4); wb_dat_i = 32'hC0DE0000 + 32'(b);
            wb_cti_i = (b == 7) ? 3'b111 : 3'b010;
            @(negedge wb_clk_i);
            checks++;
            if (wb_ack_o !== 1'b1) begin
                failures++; $display("FAIL lin_beat_ack beat %0d: ack=%b expected 1", b, wb_ack_o);
            end
        end
        @(posedge wb_clk_i); #1; idle_bus();
        for (int b = 0; b < 8; b++) begin
            classic(1'b0, 32'(b * 4), 32'h0, 4'hF, e, a, r, d, l);
            checks++;
            if (d !== 32'hC0DE0000 + 32'(b)) begin
                failures++; $display("FAIL lin_readback word %0d: got %h expected %h", b, d, 32'hC0DE0000 + 32'(b));
            end
        end
    endtask

    task automatic test_out_of_range();
        logic e, a, r, l; logic [31:0] d; logic [7:0] acks, errs; logic [255:0] dats;
        classic(1'b0, 32'h400, 32'h0, 4'hF, e, a, r, d, l);
        checks++;
        if ({e, a, r, l} !== 4'b0010 || d !== 32'h0) begin
            failures++; $display("FAIL oor_read: early/ack/err/late=%b%b%b%b dat=%h expected 0010 and 0", e, a, r, l, d);
        end
        classic(1'b1, 32'h400, 32'h0BAD0BAD, 4'hF, e, a, r, d, l);
        classic(1'b0, 32'h0, 32'h0, 4'hF, e, a, r, d, l);
        checks++;
        if (d !== 32'hC0DE0000) begin
            failures++; $display("FAIL oor_write_alias: got %h expected c0de0000", d);
        end
        read_burst(32'h3F8, 2'b00, 3, e, acks, errs, dats);
        checks++;
        if (acks[2:0] !== 3'b011 || errs[2:0] !== 3'b100) begin
            failures++; $display("FAIL oor_burst_term: acks=%b errs=%b expected 011 100", acks[2:0], errs[2:0]);
        end
        checks++;
        if (dats[63:0] !== {32'h5A0003FC, 32'h5A0003F8} || dats[95:64] !== 32'h0) begin
            failures++; $display("FAIL oor_burst_data: got %h expected 000000005a0003fc5a0003f8", dats[95:0]);
        end
    endtask

    task automatic test_reset_mid_burst();
        @(posedge wb_clk_i); #1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'h40;
        wb_sel_i = 4'hF; wb_cti_i = 3'b010; wb_bte_i = 2'b00;
        @(posedge wb_clk_i); #1;
        @(negedge wb_clk_i);
        checks++;
        if (wb_ack_o !== 1'b1 || wb_dat_o !== 32'hA5000040) begin
            failures++; $display("FAIL rst_burst_beat1: ack=%b dat=%h expected 1 a5000040", wb_ack_o, wb_dat_o);
        end
        @(posedge wb_clk_i); #1; wb_rst_i = 1'b1;
        @(negedge wb_clk_i);
        checks++;
        if (wb_ack_o !== 1'b0 || wb_dat_o !== 32'h0) begin
            failures++; $display("FAIL rst_abort: ack=%b dat=%h expected 0 0", wb_ack_o, wb_dat_o);
        end
        @(posedge wb_clk_i); #1; wb_rst_i = 1'b0;
        wb_adr_i = 32'h44; wb_cti_i = 3'b000;
        @(negedge wb_clk_i);
        checks++;
        if (wb_ack_o !== 1'b0) begin
            failures++; $display("FAIL rst_release_early: ack=%b expected 0", wb_ack_o);
        end
        @(negedge wb_clk_i);
        checks++;
        if (wb_ack_o !== 1'b1 || wb_dat_o !== 32'hA5000044) begin
            failures++; $display("FAIL rst_release_read: ack=%b dat=%h expected 1 a5000044", wb_ack_o, wb_dat_o);
        end
        @(posedge wb_clk_i); #1; idle_bus();
    endtask

    initial begin
        test_reset();
        test_classic();
        test_byte_lanes();
        test_cyc_drop();
        preload();
        test_wrap();
        test_linear_write_gap();
        test_out_of_range();
        test_reset_mid_burst();
        repeat (2) @(posedge wb_clk_i);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
